bp_fe_mem_arbiter: RTL and testbench
====================================

# bp_fe_mem_arbiter

Arbiter and sequencer for the front-end memory command port, the shared I$/ITLB request channel. It merges two sources onto the one port: speculative fetch requests from PC generation, and maintenance requests (ITLB fill, ITLB fence, I$ fence). It counts fetches in flight and drains them before any fence is issued, so fences never overtake outstanding fetches.

## Interface
Parameters:
- cmd_width_p, default 128: width of a packed mem command.
- max_inflight_p, default 2: maximum number of fetches accepted but not yet resolved.
- cnt_width_lp, localparam: `$clog2(max_inflight_p+1)`.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- fetch_cmd_i  in  cmd_width_p  fetch command.
- fetch_v_i  in  1  fetch command valid; may drop without being accepted (speculative).
- fetch_yumi_o  out  1  fetch accepted by the mem port this cycle.
- maint_cmd_i  in  cmd_width_p  maintenance command; the requester holds it until yumi.
- maint_v_i  in  1  maintenance valid.
- maint_fence_i  in  1  qualifies maint_v_i; 1 means the command is a fence and needs a drain.
- maint_yumi_o  out  1  maintenance accepted by the mem port this cycle.
- mem_cmd_o  out  cmd_width_p  command to I$/ITLB.
- mem_cmd_v_o  out  1  mem_cmd_o valid.
- mem_cmd_yumi_i  in  1  mem port consumes mem_cmd_o.
- mem_resp_v_i  in  1  one in-flight fetch has resolved (hit, miss or exception).
- mem_poison_i  in  1  the youngest in-flight fetch is killed; no response will come for it.
- inflight_o  out  cnt_width_lp  current in-flight count.
- busy_o  out  1  a fence is pending (state is not IDLE).
- error_o  out  1  sticky: a decrement arrived at count 0, or an increment arrived at max_inflight_p.

## Operation
States:
- IDLE
  - A non-fence maintenance request (maint_v_i & ~maint_fence_i) has priority over fetch and is muxed to mem_cmd_o. mem_cmd_v_o=1. maint_yumi_o = mem_cmd_yumi_i.
  - With no maintenance request, a fetch is presented when fetch_v_i is high and fetch room exists: mem_cmd_v_o = fetch_v_i & room, fetch_yumi_o = mem_cmd_yumi_i & fetch_v_i & room.
  - maint_v_i & maint_fence_i moves the state to DRAIN. The fence is not presented this cycle, and fetch is blocked in the same cycle.
- DRAIN
  - Fetch is blocked; mem_cmd_v_o=0.
  - When inflight_r==0, the state moves to ISSUE.
- ISSUE
  - mem_cmd_o = maint_cmd_i, mem_cmd_v_o=1, fetch blocked.
  - On mem_cmd_yumi_i: maint_yumi_o=1 and the state moves to IDLE.

Fetch room and the in-flight counter:
- room = (inflight_r < max_inflight_p) | dec, where dec = mem_resp_v_i | mem_poison_i.
- inc = fetch_yumi_o.
- inflight_n = inflight_r + inc − dec. mem_resp_v_i and mem_poison_i in the same cycle count as a single decrement.
- A decrement at count 0 is ignored and sets error_o.

Other rules:
- mem_cmd_o when idle (no valid command) drives the fetch_cmd_i mux leg. Its value is don't-care, but it must be deterministic.
- maint_cmd_i and maint_fence_i must stay stable from assertion until maint_yumi_o. If maint_v_i drops in DRAIN or ISSUE, the state returns to IDLE and error_o is set.
- Outputs fetch_yumi_o, maint_yumi_o and mem_cmd_v_o are combinational from inputs and state; there are no paths from yumi outputs to yumi inputs.

## Timing
- Reset values: state IDLE, inflight_o=0, busy_o=0, error_o=0, mem_cmd_v_o=0, fetch_yumi_o=0, maint_yumi_o=0. Reset is asynchronous: asserting reset mid-drain aborts the fence, and no yumi is produced afterwards.
- Fetch and non-fence maintenance have zero-cycle latency: request to mem_cmd_v_o in the same cycle.
- Fence has a minimum latency of 2 cycles: cycle 0 in IDLE sees the request, cycle 1 in DRAIN sees count 0, cycle 2 in ISSUE presents the fence with mem_cmd_v_o=1.
- In DRAIN, the count reaching 0 via dec in cycle N moves the state to ISSUE in cycle N+2. The exit test uses the registered count.
- Simultaneous accept and resolve at inflight=max: the fetch is allowed and the count is unchanged.
- inflight_o and busy_o are registered; error_o is registered and sticky until reset.

## Test plan
- Back-to-back fetches, max_inflight_p=2, no responses: cycles 0 and 1 accepted, cycle 2 blocked (mem_cmd_v_o=0, inflight_o=2). mem_resp_v_i in cycle 3 allows a fetch in cycle 3, and inflight_o stays 2.
- ITLB fill with fetch_v_i=1 at the same time: maint muxed out, maint_yumi_o=1, fetch_yumi_o=0, inflight_o unchanged.
- Fence with inflight=2: DRAIN holds mem_cmd_v_o=0. Responses arrive at cycles 2 and 4, and ISSUE begins at cycle 6. mem_cmd_yumi_i held low for 3 cycles keeps ISSUE with mem_cmd_v_o=1 throughout. On yumi, maint_yumi_o=1 and the next cycle is IDLE.
- Poison: accept 1 fetch, then mem_poison_i → inflight_o=0. Poison and resp together at count 1 → 0, no error.
- Decrement at count 0 → inflight_o stays 0, error_o=1 and remains set.
- Async reset asserted in DRAIN with inflight=1 → state IDLE, all outputs 0 immediately, and fetch accepted on the first cycle after reset release.

Source files
------------

// File: rtl/bp_fe_mem_arbiter.sv
// Front-end mem command port arbiter: merges speculative fetches with ITLB/I$
// maintenance, tracks fetches in flight and drains them before issuing a fence.
module bp_fe_mem_arbiter #(
  parameter int unsigned cmd_width_p    = 128,
  parameter int unsigned max_inflight_p = 2,
  localparam int unsigned cnt_width_lp  = $clog2(max_inflight_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,

  input  logic [cmd_width_p-1:0]  fetch_cmd_i,
  input  logic                    fetch_v_i,
  output logic                    fetch_yumi_o,

  input  logic [cmd_width_p-1:0]  maint_cmd_i,
  input  logic                    maint_v_i,
  input  logic                    maint_fence_i,
  output logic                    maint_yumi_o,

  output logic [cmd_width_p-1:0]  mem_cmd_o,
  output logic                    mem_cmd_v_o,
  input  logic                    mem_cmd_yumi_i,

  input  logic                    mem_resp_v_i,
  input  logic                    mem_poison_i,

  output logic [cnt_width_lp-1:0] inflight_o,
  output logic                    busy_o,
  output logic                    error_o
);

  localparam logic [cnt_width_lp-1:0] max_cnt_lp = cnt_width_lp'(max_inflight_p);

  typedef enum logic [1:0] {StIdle, StDrain, StIssue} state_e;

  state_e                  state_q;
  logic [cnt_width_lp-1:0] inflight_q, inflight_d;
  logic                    error_q;

  logic dec, room, dec_ok, dec_err, inc_err, prot_err;

  // Command mux and handshakes; everything is quiet while reset is held.
  always_comb begin
    dec          = mem_resp_v_i | mem_poison_i;
    room         = (inflight_q < max_cnt_lp) | dec;
    mem_cmd_o    = fetch_cmd_i;
    mem_cmd_v_o  = 1'b0;
    fetch_yumi_o = 1'b0;
    maint_yumi_o = 1'b0;
    if (!reset_i) begin
      case (state_q)
        StIdle: begin
          if (maint_v_i & ~maint_fence_i) begin
            mem_cmd_o    = maint_cmd_i;
            mem_cmd_v_o  = 1'b1;
            maint_yumi_o = mem_cmd_yumi_i;
          end else if (!maint_v_i) begin
            // A fence request blocks fetch in the cycle it is first seen.
            mem_cmd_v_o  = fetch_v_i & room;
            fetch_yumi_o = mem_cmd_yumi_i & fetch_v_i & room;
          end
        end
        StIssue: begin
          mem_cmd_o    = maint_cmd_i;
          mem_cmd_v_o  = maint_v_i;
          maint_yumi_o = mem_cmd_yumi_i & maint_v_i;
        end
        default: ;
      endcase
    end
  end

  // In-flight count next state; resp and poison together are one decrement.
  always_comb begin
    dec_ok     = dec & (inflight_q != '0);
    dec_err    = dec & (inflight_q == '0);
    inc_err    = fetch_yumi_o & ~dec_ok & (inflight_q == max_cnt_lp);
    prot_err   = (state_q != StIdle) & ~maint_v_i;
    inflight_d = inflight_q + cnt_width_lp'(fetch_yumi_o) - cnt_width_lp'(dec_ok);
  end

  // Fence sequencer: drain on the registered count, then present the fence.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (maint_v_i & maint_fence_i) state_q <= StDrain;
        end
        StDrain: begin
          if (!maint_v_i)              state_q <= StIdle;
          else if (inflight_q == '0)   state_q <= StIssue;
        end
        StIssue: begin
          if (!maint_v_i || mem_cmd_yumi_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Counter and sticky error flag.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      inflight_q <= '0;
      error_q    <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      error_q    <= error_q | dec_err | inc_err | prot_err;
    end
  end

  assign inflight_o = inflight_q;
  assign busy_o     = (state_q != StIdle);
  assign error_o    = error_q;

endmodule

// File: tb/tb_bp_fe_mem_arbiter.sv
// Randomized scoreboard bench for bp_fe_mem_arbiter with directed scenarios.
module tb_bp_fe_mem_arbiter;
  localparam int unsigned W   = 128;
  localparam int unsigned MAX = 2;
  localparam int unsigned CW  = $clog2(MAX + 1);

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [W-1:0]  fetch_cmd_i, maint_cmd_i, mem_cmd_o;
  logic          fetch_v_i, fetch_yumi_o, maint_v_i, maint_fence_i, maint_yumi_o;
  logic          mem_cmd_v_o, mem_cmd_yumi_i, mem_resp_v_i, mem_poison_i;
  logic [CW-1:0] inflight_o;
  logic          busy_o, error_o;

  always #5 clk_i = ~clk_i;

  bp_fe_mem_arbiter #(.cmd_width_p(W), .max_inflight_p(MAX)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .fetch_cmd_i(fetch_cmd_i), .fetch_v_i(fetch_v_i), .fetch_yumi_o(fetch_yumi_o),
    .maint_cmd_i(maint_cmd_i), .maint_v_i(maint_v_i), .maint_fence_i(maint_fence_i),
    .maint_yumi_o(maint_yumi_o),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_yumi_i(mem_cmd_yumi_i),
    .mem_resp_v_i(mem_resp_v_i), .mem_poison_i(mem_poison_i),
    .inflight_o(inflight_o), .busy_o(busy_o), .error_o(error_o)
  );

  typedef struct {
    logic         v, fy, my, busy, err;
    logic [W-1:0] cmd;
    int           infl;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: fetches in flight, fence pending, drain observed complete.
  int m_cnt   = 0;
  bit m_fence = 1'b0;
  bit m_armed = 1'b0;
  bit m_err   = 1'b0;
  bit last_my = 1'b0;

  function automatic logic [W-1:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and queue what the port must do in that cycle.
  task automatic step(input bit rst, input bit fv, input logic [W-1:0] fcmd,
                      input bit mv, input bit mf, input logic [W-1:0] mcmd,
                      input bit yumi, input bit resp, input bit poison);
    exp_t e;
    bit   dec, room;
    @(negedge clk_i);
    reset_i = rst; fetch_v_i = fv; fetch_cmd_i = fcmd; maint_v_i = mv;
    maint_fence_i = mf; maint_cmd_i = mcmd; mem_cmd_yumi_i = yumi;
    mem_resp_v_i = resp; mem_poison_i = poison;
    e.v = 1'b0; e.fy = 1'b0; e.my = 1'b0; e.cmd = '0;
    if (rst) begin
      m_cnt = 0; m_fence = 1'b0; m_armed = 1'b0; m_err = 1'b0;
      e.infl = 0; e.busy = 1'b0; e.err = 1'b0;
    end else begin
      e.infl = m_cnt; e.busy = m_fence; e.err = m_err;
      dec  = resp | poison;
      room = (m_cnt < MAX) || dec;
      if (!m_fence) begin
        if (mv && !mf) begin
          e.v = 1'b1; e.cmd = mcmd; e.my = yumi;
        end else if (mv) begin
          m_fence = 1'b1; m_armed = 1'b0;
        end else if (fv && room) begin
          e.v = 1'b1; e.cmd = fcmd; e.fy = yumi;
        end
      end else if (!m_armed) begin
        if (m_cnt == 0) m_armed = 1'b1;
      end else begin
        e.v = 1'b1; e.cmd = mcmd; e.my = yumi;
        if (yumi) m_fence = 1'b0;
      end
      if (dec) begin
        if (m_cnt == 0) m_err = 1'b1;
        else            m_cnt--;
      end
      if (e.fy) m_cnt++;
    end
    last_my = e.my;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, '0, 0, 0, 0);
  endtask

  // Monitor: compare each queued expectation with the port mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("mem_cmd_v", W'(mem_cmd_v_o), W'(e.v));
        chk("fetch_yumi", W'(fetch_yumi_o), W'(e.fy));
        chk("maint_yumi", W'(maint_yumi_o), W'(e.my));
        chk("inflight", W'(inflight_o), W'(e.infl));
        chk("busy", W'(busy_o), W'(e.busy));
        chk("error", W'(error_o), W'(e.err));
        if (e.v) chk("mem_cmd", mem_cmd_o, e.cmd);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] fc, mc;
    bit           ma, maf, rsp, psn;
    logic [W-1:0] mac;
    int           guard;

    reset_i = 1'b1; fetch_v_i = 1'b0; fetch_cmd_i = '0; maint_v_i = 1'b0;
    maint_fence_i = 1'b0; maint_cmd_i = '0; mem_cmd_yumi_i = 1'b0;
    mem_resp_v_i = 1'b0; mem_poison_i = 1'b0;
    step(1, 1, r128(), 0, 0, '0, 1, 0, 0);
    step(1, 0, '0, 0, 0, '0, 0, 0, 0);

    // Back-to-back fetches up to the limit, then resolve-and-accept at max.
    fc = r128();
    step(0, 1, fc, 0, 0, '0, 1, 0, 0);
    step(0, 1, fc + 1, 0, 0, '0, 1, 0, 0);
    step(0, 1, fc + 2, 0, 0, '0, 1, 0, 0);
    #2 chk("b2b_blocked", W'(mem_cmd_v_o), W'(0));
    step(0, 1, fc + 3, 0, 0, '0, 1, 1, 0);
    #2 chk("b2b_max_accept", W'(fetch_yumi_o), W'(1));
    idle();
    #2 chk("b2b_infl", W'(inflight_o), W'(2));
    step(0, 0, '0, 0, 0, '0, 0, 1, 0);
    step(0, 0, '0, 0, 0, '0, 0, 1, 0);

    // ITLB fill competing with a fetch.
    mc = r128();
    step(0, 1, r128(), 1, 0, mc, 1, 0, 0);
    #2 chk("fill_cmd", mem_cmd_o, mc);

    // Fence with two fetches outstanding.
    step(0, 1, r128(), 0, 0, '0, 1, 0, 0);
    step(0, 1, r128(), 0, 0, '0, 1, 0, 0);
    mc = r128();
    step(0, 1, r128(), 1, 1, mc, 1, 0, 0);   // c0
    step(0, 1, r128(), 1, 1, mc, 1, 0, 0);   // c1
    step(0, 0, '0, 1, 1, mc, 1, 1, 0);       // c2
    step(0, 0, '0, 1, 1, mc, 1, 0, 0);       // c3
    step(0, 0, '0, 1, 1, mc, 1, 1, 0);       // c4
    step(0, 1, r128(), 1, 1, mc, 0, 0, 0);   // c5
    #2 chk("fence_drain_v", W'(mem_cmd_v_o), W'(0));
    step(0, 1, r128(), 1, 1, mc, 0, 0, 0);   // c6
    #2 chk("fence_issue_v", W'(mem_cmd_v_o), W'(1));
    step(0, 1, r128(), 1, 1, mc, 0, 0, 0);   // c7
    step(0, 1, r128(), 1, 1, mc, 0, 0, 0);   // c8
    step(0, 1, r128(), 1, 1, mc, 1, 0, 0);   // c9
    #2 chk("fence_yumi", W'(maint_yumi_o), W'(1));
    idle();
    #2 chk("fence_done_busy", W'(busy_o), W'(0));

    // Poison alone, then poison and response together at count 1.
    step(0, 1, r128(), 0, 0, '0, 1, 0, 0);
    step(0, 0, '0, 0, 0, '0, 0, 0, 1);
    step(0, 1, r128(), 0, 0, '0, 1, 0, 0);
    step(0, 0, '0, 0, 0, '0, 0, 1, 1);
    idle();
    #2 chk("poison_err", W'(error_o), W'(0));

    // Randomized traffic with a well-behaved maintenance requester.
    ma = 1'b0; maf = 1'b0; mac = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!ma && $urandom_range(0, 5) == 0) begin
        ma = 1'b1; maf = ($urandom_range(0, 2) == 0); mac = r128();
      end
      rsp = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
      psn = (m_cnt > 0) && ($urandom_range(0, 7) == 0);
      step(0, 1'($urandom_range(0, 1)), r128(), ma, maf, mac,
           ($urandom_range(0, 3) != 0), rsp, psn);
      if (last_my) ma = 1'b0;
    end
    guard = 0;
    while ((ma || m_cnt > 0) && guard < 100) begin
      step(0, 0, '0, ma, maf, mac, 1, (m_cnt > 0), 0);
      if (last_my) ma = 1'b0;
      guard++;
    end
    chk("rand_settle", W'(guard < 100), W'(1));

    // Decrement at zero is ignored and the error sticks.
    step(0, 0, '0, 0, 0, '0, 0, 1, 0);
    idle();
    idle();
    #2 chk("err_sticky", W'(error_o), W'(1));

    // Async reset during a drain with one fetch outstanding.
    step(0, 1, r128(), 0, 0, '0, 1, 0, 0);
    mc = r128();
    step(0, 0, '0, 1, 1, mc, 0, 0, 0);
    step(0, 0, '0, 1, 1, mc, 0, 0, 0);
    #2 chk("pre_rst_busy", W'(busy_o), W'(1));
    step(1, 1, r128(), 1, 1, mc, 1, 0, 0);
    #2 chk("rst_busy", W'(busy_o), W'(0));
    chk("rst_v", W'(mem_cmd_v_o), W'(0));
    chk("rst_infl", W'(inflight_o), W'(0));
    step(0, 1, r128(), 0, 0, '0, 1, 0, 0);
    #2 chk("post_rst_fetch", W'(fetch_yumi_o), W'(1));
    idle();
    idle();

    @(negedge clk_i);
    #3;
    chk("sb_empty", W'(sb_q.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
